fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Controller that sequences an in-place radix-2 decimation-in-time FFT over a dual-port sample memory, reusing the single `butterfly` datapath for every butterfly of every stage. Per cycle it issues one butterfly's operand read addresses and twiddle index. After the butterfly pipeline latency it issues the matching write-back addresses. Between stages it drains the pipeline so that no read-after-write hazard occurs. Bit-reversed loading of input samples belongs to the upstream loader, not this block.

## Interface
- `N_LOG2`, 3: log2 of FFT length N (N = 8 by default); legal range 2..12.
- `BF_LAT`, 2: cycles from a read-address cycle to its write-back cycle (memory read plus registered butterfly); legal range ≥ 1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `busy`  out  1  high from the first read cycle through the last write cycle.
- `done`  out  1  one-cycle pulse when the transform completes.
- `stage`  out  N_LOG2  current stage index s, aligned with `rd_en`.
- `rd_en`  out  1  read strobe for both memory ports.
- `rd_addr_a`, `rd_addr_b`  out  N_LOG2 each  butterfly operand addresses a and b.
- `tw_idx`  out  N_LOG2-1  twiddle ROM index, aligned with `rd_en`.
- `wr_en`  out  1  write-back strobe; equals `rd_en` delayed by BF_LAT.
- `wr_addr_a`, `wr_addr_b`  out  N_LOG2 each  `rd_addr_a` and `rd_addr_b` delayed by BF_LAT.

## Operation
- FSM has three states: IDLE, READ and DRAIN. All outputs are registered.
- **IDLE:** if `start`=1, clear s=0 and k=0, then go to READ.
- **READ:** each cycle assert `rd_en` with butterfly k (0..N/2-1) of stage s. Address and twiddle rules:
  - half = 2^s
  - a = ((k >> s) << (s+1)) | (k & (half-1))
  - b = a + half
  - tw_idx = (k & (half-1)) << (N_LOG2-1-s)
  - After k = N/2-1, go to DRAIN.
- **DRAIN:** hold for exactly BF_LAT cycles with `rd_en`=0.
  - If s < N_LOG2-1: increment s, clear k, go to READ.
  - Else: go to IDLE.
- Write path: a BF_LAT-deep shift register carries {rd_en, rd_addr_a, rd_addr_b} to {wr_en, wr_addr_a, wr_addr_b}. It runs every cycle regardless of state.
- `start` is ignored outside IDLE. No queuing.
- **Reset:** state goes to IDLE, s=k=0, and the delay line is cleared. Reset values of all outputs are 0: `busy`, `done`, `rd_en`, `wr_en`, `stage`, all addresses and `tw_idx`. A reset mid-transform kills in-flight writes (`wr_en` is 0 from the cycle after reset) and no `done` is produced.

## Timing
- Cycle numbering: `start` is sampled at edge 0. The first `rd_en` is high in cycle 1.
- Each stage occupies N/2 + BF_LAT cycles.
- Reads of stage s+1 begin the cycle after the final write of stage s. This is the hazard-free ordering for a synchronous write-first RAM.
- The last write occurs in cycle N_LOG2·(N/2+BF_LAT). `busy` is high in cycles 1 through that cycle.
- `done`=1 and `busy`=0 in cycle N_LOG2·(N/2+BF_LAT)+1. The FSM is in IDLE in that cycle, so a `start` sampled then is accepted and its reads begin in the next cycle.
- `wr_en` is never high in a cycle where `rd_en` targets the same address.

## Test plan
- **Default params, `start` pulse at cycle 0:**
  - Stage 0 reads cycles 1–4 with (a,b) = (0,1),(2,3),(4,5),(6,7) and `tw_idx` = 0.
  - Stage 1 reads cycles 7–10 with (0,2),(1,3),(4,6),(5,7) and `tw_idx` = 0,2,0,2.
  - Stage 2 reads cycles 13–16 with (0,4),(1,5),(2,6),(3,7) and `tw_idx` = 0,1,2,3.
  - `done` pulses at cycle 19 only.
- **Write alignment:** `wr_en`/`wr_addr` equal the `rd_*` values from 2 cycles earlier. Writes occur in cycles 3–6, 9–12 and 15–18. `rd_en` and `wr_en` are never both high in stage-boundary cycles 5–6 and 11–12.
- **`start` held high throughout:** no restart while busy. A second transform's first read lands at cycle 20, and `done` pulses at 19 and 38.
- **Reset:** assert `rst` at cycle 8 (mid-stage 1). From cycle 9, all outputs are 0, `wr_en` stays 0, and `done` never pulses. A new `start` then yields the full cycle-1 sequence relative to that `start`.
- **N_LOG2=2, BF_LAT=1:**
  - Reads in cycles 1–2 with (0,1),(2,3) and `tw_idx` 0.
  - Reads in cycles 4–5 with (0,2),(1,3) and `tw_idx` 0,1.
  - `done` pulses at cycle 7.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT sharing one butterfly.
// Issues one butterfly read per cycle, drains the pipeline between stages, and delays reads into write-backs.
module fft_stage_sequencer #(
  parameter int N_LOG2 = 3,
  parameter int BF_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-1:0] stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_idx,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
  output logic [1:0]        dbg_state
);

  localparam int AW     = N_LOG2;
  localparam int KW     = N_LOG2 - 1;
  localparam int HALF_N = 1 << (N_LOG2 - 1);
  localparam int CW     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int DW     = 1 + 2 * AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // start is a level, not a handshake: it is looked at only while IDLE and never queued.
  state_t          state_q, state_d;
  logic [AW-1:0]   s_q, s_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_a_q, rd_a_d;
  logic [AW-1:0]   rd_b_q, rd_b_d;
  logic [KW-1:0]   tw_q, tw_d;
  logic [DW-1:0]   dl_q [BF_LAT];

  function automatic logic [AW-1:0] bf_addr_a(input logic [AW-1:0] s, input logic [KW-1:0] k);
    logic [AW-1:0] kx;
    logic [AW-1:0] mask;
    kx   = {1'b0, k};
    mask = (AW'(1) << s) - AW'(1);
    return ((kx >> s) << (s + AW'(1))) | (kx & mask);
  endfunction

  function automatic logic [KW-1:0] bf_tw(input logic [AW-1:0] s, input logic [KW-1:0] k);
    logic [AW-1:0] kx;
    logic [AW-1:0] mask;
    logic [AW-1:0] t;
    kx   = {1'b0, k};
    mask = (AW'(1) << s) - AW'(1);
    t    = (kx & mask) << (AW'(AW - 1) - s);
    return t[KW-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_READ;
          s_d     = '0;
          k_d     = '0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_READ: begin
        busy_d = 1'b1;
        if (k_q == KW'(HALF_N - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          k_d     = k_q + KW'(1);
          rd_en_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        // The last drain cycle carries the final write of the stage.
        if (cnt_q == CW'(BF_LAT - 1)) begin
          if (s_q == AW'(N_LOG2 - 1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_READ;
            s_d     = s_q + AW'(1);
            k_d     = '0;
            rd_en_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rd_a_d = rd_en_d ? bf_addr_a(s_d, k_d) : '0;
    rd_b_d = rd_en_d ? (bf_addr_a(s_d, k_d) + (AW'(1) << s_d)) : '0;
    tw_d   = rd_en_d ? bf_tw(s_d, k_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
    end
  end

  // Write-back delay line; clearing it on reset kills in-flight writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BF_LAT; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= {rd_en_q, rd_a_q, rd_b_q};
      for (int i = 1; i < BF_LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = s_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_idx    = tw_q;
  assign {wr_en, wr_addr_a, wr_addr_b} = dl_q[BF_LAT-1];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: randomized start/reset traffic against a transaction-level schedule model,
// plus directed timing points and a small N_LOG2=2, BF_LAT=1 instance.
module tb_fft_stage_sequencer;

  localparam int NL   = 3;
  localparam int L    = 2;
  localparam int H    = 1 << (NL - 1);
  localparam int D    = NL * (H + L) + 1;
  localparam int MAXC = 700;

  logic clk = 1'b0;
  logic rst, start, rst2, start2;

  logic       busy, done, rd_en, wr_en;
  logic [2:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_idx, dbg_state;

  logic       s_busy, s_done, s_rd_en, s_wr_en;
  logic [1:0] s_stage, s_ra, s_rb, s_wa, s_wb, s_dbg;
  logic [0:0] s_tw;

  int total = 0;
  int bad   = 0;

  logic       stim_start [MAXC];
  logic       stim_rst   [MAXC];
  logic       e_rd [MAXC], e_wr [MAXC], e_busy [MAXC], e_done [MAXC];
  logic [2:0] e_a [MAXC], e_b [MAXC], e_wa [MAXC], e_wb [MAXC], e_stage [MAXC];
  logic [1:0] e_tw [MAXC];
  logic       a_rd [MAXC], a_wr [MAXC], a_done [MAXC];
  logic [2:0] a_a [MAXC], a_b [MAXC], a_wa [MAXC], a_wb [MAXC];
  logic [1:0] a_tw [MAXC];

  int sm_a  [10] = '{0, 0, 2, 0, 0, 1, 0, 0, 0, 0};
  int sm_b  [10] = '{0, 1, 3, 0, 2, 3, 0, 0, 0, 0};
  int sm_tw [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  int sm_st [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};

  always #5 clk = ~clk;

  fft_stage_sequencer #(.N_LOG2(NL), .BF_LAT(L)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .dbg_state(dbg_state)
  );

  fft_stage_sequencer #(.N_LOG2(2), .BF_LAT(1)) u_small (
    .clk(clk), .rst(rst2), .start(start2), .busy(s_busy), .done(s_done), .stage(s_stage),
    .rd_en(s_rd_en), .rd_addr_a(s_ra), .rd_addr_b(s_rb), .tw_idx(s_tw),
    .wr_en(s_wr_en), .wr_addr_a(s_wa), .wr_addr_b(s_wb), .dbg_state(s_dbg)
  );

  // Schedule model: each accepted start at cycle c occupies cycles c+1..c+D-1, butterfly (s,k)
  // reads at c+1+s*(H+L)+k and writes L cycles later; a reset wipes everything after it.
  task automatic build_model(input int len);
    bit active = 0;
    int t0 = 0;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_wr[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      e_a[c] = 0; e_b[c] = 0; e_wa[c] = 0; e_wb[c] = 0; e_tw[c] = 0; e_stage[c] = 0;
    end
    for (int c = 0; c < len; c++) begin
      if (stim_rst[c]) begin
        active = 0;
        for (int j = c + 1; j < MAXC; j++) begin
          e_rd[j] = 0; e_wr[j] = 0; e_busy[j] = 0; e_done[j] = 0;
        end
      end else if (stim_start[c] && (!active || c >= t0 + D)) begin
        active = 1;
        t0 = c;
        for (int j = c + 1; j < c + D; j++) e_busy[j] = 1;
        e_done[c + D] = 1;
        for (int s = 0; s < NL; s++) begin
          for (int k = 0; k < H; k++) begin
            int half, rc, a;
            half = 1 << s;
            rc = c + 1 + s * (H + L) + k;
            a = (k / half) * 2 * half + (k % half);
            e_rd[rc] = 1; e_a[rc] = 3'(a); e_b[rc] = 3'(a + half);
            e_tw[rc] = 2'((k % half) * (H / half)); e_stage[rc] = 3'(s);
            e_wr[rc + L] = 1; e_wa[rc + L] = 3'(a); e_wb[rc + L] = 3'(a + half);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 1; rst2 = 1; start2 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({busy, done, rd_en, wr_en} !== 4'b0) begin bad++; $display("FAIL reset_flags got %b exp 0000", {busy, done, rd_en, wr_en}); end
    total++; if ({stage, rd_addr_a, rd_addr_b, tw_idx} !== 11'b0) begin bad++; $display("FAIL reset_rd_fields got %h exp 0", {stage, rd_addr_a, rd_addr_b, tw_idx}); end
    total++; if ({wr_addr_a, wr_addr_b, dbg_state} !== 8'b0) begin bad++; $display("FAIL reset_wr_fields got %h exp 0", {wr_addr_a, wr_addr_b, dbg_state}); end
    total++; if ({s_busy, s_done, s_rd_en, s_wr_en, s_stage, s_ra, s_rb, s_tw, s_wa, s_wb} !== 15'b0) begin
      bad++; $display("FAIL reset_small got %h exp 0", {s_busy, s_done, s_rd_en, s_wr_en, s_stage, s_ra, s_rb, s_tw, s_wa, s_wb});
    end
    start = 0; start2 = 0;
  endtask

  // kind: 0 single start, 1 start held high, 2 reset mid stage 1, 3 random traffic, 4 back to back
  task automatic test_scenario(input int kind);
    int len;
    int ndone;
    case (kind)
      0: len = 45;
      1: len = 60;
      2: len = 55;
      4: len = 64;
      default: len = 400;
    endcase
    for (int c = 0; c < MAXC; c++) begin
      stim_start[c] = 0; stim_rst[c] = 0;
    end
    case (kind)
      0: stim_start[0] = 1;
      1: for (int c = 0; c < len; c++) stim_start[c] = 1;
      2: begin stim_start[0] = 1; stim_rst[8] = 1; stim_start[12] = 1; end
      4: begin stim_start[0] = 1; stim_start[10] = 1; stim_start[19] = 1; stim_start[30] = 1; end
      default: for (int c = 0; c < len; c++) begin
        stim_start[c] = ($urandom_range(0, 3) == 0);
        stim_rst[c]   = ($urandom_range(0, 149) == 0);
      end
    endcase
    build_model(len);
    rst = 1; start = 0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      a_rd[c] = rd_en; a_wr[c] = wr_en; a_done[c] = done;
      a_a[c] = rd_addr_a; a_b[c] = rd_addr_b; a_tw[c] = tw_idx; a_wa[c] = wr_addr_a; a_wb[c] = wr_addr_b;
      total++; if (busy !== e_busy[c]) begin bad++; $display("FAIL busy k%0d c%0d got %b exp %b", kind, c, busy, e_busy[c]); end
      total++; if (done !== e_done[c]) begin bad++; $display("FAIL done k%0d c%0d got %b exp %b", kind, c, done, e_done[c]); end
      total++; if (rd_en !== e_rd[c]) begin bad++; $display("FAIL rd_en k%0d c%0d got %b exp %b", kind, c, rd_en, e_rd[c]); end
      total++; if (wr_en !== e_wr[c]) begin bad++; $display("FAIL wr_en k%0d c%0d got %b exp %b", kind, c, wr_en, e_wr[c]); end
      if (e_rd[c]) begin
        total++; if ({rd_addr_a, rd_addr_b} !== {e_a[c], e_b[c]}) begin
          bad++; $display("FAIL rd_addr k%0d c%0d got %0d,%0d exp %0d,%0d", kind, c, rd_addr_a, rd_addr_b, e_a[c], e_b[c]);
        end
        total++; if (tw_idx !== e_tw[c]) begin bad++; $display("FAIL tw_idx k%0d c%0d got %0d exp %0d", kind, c, tw_idx, e_tw[c]); end
        total++; if (stage !== e_stage[c]) begin bad++; $display("FAIL stage k%0d c%0d got %0d exp %0d", kind, c, stage, e_stage[c]); end
      end
      if (e_wr[c]) begin
        total++; if ({wr_addr_a, wr_addr_b} !== {e_wa[c], e_wb[c]}) begin
          bad++; $display("FAIL wr_addr k%0d c%0d got %0d,%0d exp %0d,%0d", kind, c, wr_addr_a, wr_addr_b, e_wa[c], e_wb[c]);
        end
      end
      if (rd_en === 1'b1 && wr_en === 1'b1) begin
        total++;
        if (rd_addr_a == wr_addr_a || rd_addr_a == wr_addr_b || rd_addr_b == wr_addr_a || rd_addr_b == wr_addr_b) begin
          bad++; $display("FAIL hazard k%0d c%0d rd %0d,%0d wr %0d,%0d", kind, c, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b);
        end
      end
      start = stim_start[c];
      rst   = stim_rst[c];
    end
    start = 0; rst = 0;
    ndone = 0;
    for (int c = 0; c < len; c++) if (a_done[c] === 1'b1) ndone++;
    if (kind == 0) begin
      total++; if ({a_rd[1], a_a[1], a_b[1], a_tw[1]} !== {1'b1, 3'd0, 3'd1, 2'd0}) begin
        bad++; $display("FAIL plan_c1 got rd=%b %0d,%0d tw=%0d exp rd=1 0,1 tw=0", a_rd[1], a_a[1], a_b[1], a_tw[1]);
      end
      total++; if ({a_rd[8], a_a[8], a_b[8], a_tw[8]} !== {1'b1, 3'd1, 3'd3, 2'd2}) begin
        bad++; $display("FAIL plan_c8 got rd=%b %0d,%0d tw=%0d exp rd=1 1,3 tw=2", a_rd[8], a_a[8], a_b[8], a_tw[8]);
      end
      total++; if ({a_rd[16], a_a[16], a_b[16], a_tw[16]} !== {1'b1, 3'd3, 3'd7, 2'd3}) begin
        bad++; $display("FAIL plan_c16 got rd=%b %0d,%0d tw=%0d exp rd=1 3,7 tw=3", a_rd[16], a_a[16], a_b[16], a_tw[16]);
      end
      total++; if ({a_rd[5], a_wr[5], a_rd[6], a_wr[6], a_rd[11], a_wr[11]} !== 6'b010101) begin
        bad++; $display("FAIL plan_boundary got %b exp 010101", {a_rd[5], a_wr[5], a_rd[6], a_wr[6], a_rd[11], a_wr[11]});
      end
      total++; if ({a_wr[3], a_wa[3], a_wb[3]} !== {1'b1, 3'd0, 3'd1}) begin
        bad++; $display("FAIL plan_wr3 got %b %0d,%0d exp 1 0,1", a_wr[3], a_wa[3], a_wb[3]);
      end
      total++; if (a_done[19] !== 1'b1 || ndone != 1) begin
        bad++; $display("FAIL plan_done got done19=%b pulses=%0d exp 1 and 1", a_done[19], ndone);
      end
    end
    if (kind == 1) begin
      total++; if ({a_rd[19], a_rd[20], a_done[19], a_done[38]} !== 4'b0111) begin
        bad++; $display("FAIL held_start got %b exp 0111", {a_rd[19], a_rd[20], a_done[19], a_done[38]});
      end
    end
    if (kind == 2) begin
      total++; if ({a_wr[9], a_wr[10], a_wr[11], a_rd[9], a_done[19], a_done[31], a_rd[13]} !== 7'b0000011) begin
        bad++; $display("FAIL reset_mid got %b exp 0000011", {a_wr[9], a_wr[10], a_wr[11], a_rd[9], a_done[19], a_done[31], a_rd[13]});
      end
    end
    if (kind == 4) begin
      total++; if ({a_done[19], a_rd[20], a_done[38], ndone} !== {3'b111, 32'd2}) begin
        bad++; $display("FAIL back_to_back got %b%b%b pulses=%0d exp 111 pulses=2", a_done[19], a_rd[20], a_done[38], ndone);
      end
    end
  endtask

  task automatic test_small_params();
    logic [9:0] x_rd, x_wr, x_busy, x_done;
    x_rd = 10'b0000110110; x_wr = 10'b0001101100;
    x_busy = 10'b0001111110; x_done = 10'b0010000000;
    rst2 = 1; start2 = 0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if ({s_rd_en, s_wr_en, s_busy, s_done} !== {x_rd[c], x_wr[c], x_busy[c], x_done[c]}) begin
        bad++; $display("FAIL small_flags c%0d got %b exp %b", c, {s_rd_en, s_wr_en, s_busy, s_done}, {x_rd[c], x_wr[c], x_busy[c], x_done[c]});
      end
      if (x_rd[c]) begin
        total++; if ({s_ra, s_rb, s_tw, s_stage} !== {2'(sm_a[c]), 2'(sm_b[c]), 1'(sm_tw[c]), 2'(sm_st[c])}) begin
          bad++; $display("FAIL small_rd c%0d got %0d,%0d tw=%0d st=%0d exp %0d,%0d tw=%0d st=%0d", c, s_ra, s_rb, s_tw, s_stage, sm_a[c], sm_b[c], sm_tw[c], sm_st[c]);
        end
      end
      if (x_wr[c]) begin
        total++; if ({s_wa, s_wb} !== {2'(sm_a[c-1]), 2'(sm_b[c-1])}) begin
          bad++; $display("FAIL small_wr c%0d got %0d,%0d exp %0d,%0d", c, s_wa, s_wb, sm_a[c-1], sm_b[c-1]);
        end
      end
      rst2 = 0;
      start2 = (c == 0);
    end
    start2 = 0;
  endtask

  initial begin
    rst = 1; start = 0; rst2 = 1; start2 = 0;
    test_reset();
    test_scenario(0);
    test_scenario(1);
    test_scenario(2);
    test_scenario(4);
    test_scenario(3);
    test_scenario(3);
    test_small_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
